// File: rtl/ant_maze_pkg.sv
// Shared codes for the ant controller and its arena model: move and heading encodings,
// pheromone width, bench clock period and the neighbour-cell lookup result.
package ant_maze_pkg;

    localparam int PH_WIDTH = 4;
    localparam int CYC      = 10;

    typedef enum logic [1:0] {
        HALT    = 2'd0,
        RIGHT   = 2'd1,
        LEFT    = 2'd2,
        FORWARD = 2'd3
    } move_e;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    typedef enum logic {
        StRun  = 1'b0,
        StDone = 1'b1
    } state_e;

    typedef struct packed {
        logic       blocked;
        logic [3:0] x;
        logic [3:0] y;
    } cell_t;

endpackage

// File: rtl/ant_ph_map.sv
// Per-cell pheromone register array: writes keep the maximum level seen, reads are combinational.
module ant_ph_map
    import ant_maze_pkg::*;
#(
    parameter int Depth = 64,
    parameter int AddrW = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [AddrW-1:0]    wr_addr,
    input  logic [PH_WIDTH-1:0] wr_data,
    input  logic [AddrW-1:0]    rd_addr,
    output logic [PH_WIDTH-1:0] rd_data
);

    logic [PH_WIDTH-1:0] r_mem [Depth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en && (wr_data > r_mem[wr_addr])) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/ant_maze_env.sv
// Grid arena driven by the ant controller's move command; returns wall sensors, hit/escape
// flags and, when CHALLENGE is set, the pheromone level of the ant's current cell.
module ant_maze_env
    import ant_maze_pkg::*;
#(
    parameter int           W         = 8,
    parameter int           H         = 8,
    parameter logic [W*H-1:0] WALL_MAP = '0,
    parameter int           START_X   = 0,
    parameter int           START_Y   = 0,
    parameter logic [1:0]   START_DIR = DIR_E,
    parameter int           EXIT_X    = W - 1,
    parameter int           EXIT_Y    = H - 1,
    parameter int           STEP_W    = 16,
    parameter bit           CHALLENGE = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          move,
    input  logic [PH_WIDTH-1:0] ph_drop,
    output logic                ant_l,
    output logic                ant_r,
    output logic                hit,
    output logic                escape,
    output logic [PH_WIDTH-1:0] ph_detected,
    output logic [3:0]          pos_x,
    output logic [3:0]          pos_y,
    output logic [1:0]          dir,
    output logic [STEP_W-1:0]   steps
);

    localparam int IdxW = (W * H > 1) ? $clog2(W * H) : 1;

    // Off-grid neighbours report blocked; x/y are only meaningful when not blocked.
    function automatic cell_t nbr(input logic [3:0] x, input logic [3:0] y, input logic [1:0] d);
        int    nx;
        int    ny;
        cell_t c;
        nx = int'(x);
        ny = int'(y);
        case (d)
            DIR_N:   ny = ny - 1;
            DIR_E:   nx = nx + 1;
            DIR_S:   ny = ny + 1;
            default: nx = nx - 1;
        endcase
        c.x = 4'(nx);
        c.y = 4'(ny);
        if (nx < 0 || nx >= W || ny < 0 || ny >= H) begin
            c.blocked = 1'b1;
        end else begin
            c.blocked = WALL_MAP[IdxW'(ny * W + nx)];
        end
        return c;
    endfunction

    state_e            r_state;
    logic [3:0]        r_x, r_y;
    logic [1:0]        r_dir;
    logic              r_hit, r_escape;
    logic [STEP_W-1:0] r_steps;

    cell_t      w_fwd;
    logic [3:0] w_x_d, w_y_d;
    logic [1:0] w_dir_d;
    logic       w_hit_d, w_count;

    assign w_fwd = nbr(r_x, r_y, r_dir);
    assign ant_l = nbr(r_x, r_y, r_dir + 2'd3).blocked;
    assign ant_r = nbr(r_x, r_y, r_dir + 2'd1).blocked;

    // Unknown or HALT codes fall through to the default and leave the ant in place.
    always_comb begin
        w_x_d   = r_x;
        w_y_d   = r_y;
        w_dir_d = r_dir;
        w_hit_d = 1'b0;
        w_count = 1'b0;
        case (move)
            RIGHT: begin
                w_dir_d = r_dir + 2'd1;
                w_count = 1'b1;
            end
            LEFT: begin
                w_dir_d = r_dir + 2'd3;
                w_count = 1'b1;
            end
            FORWARD: begin
                w_count = 1'b1;
                if (w_fwd.blocked) begin
                    w_hit_d = 1'b1;
                end else begin
                    w_x_d = w_fwd.x;
                    w_y_d = w_fwd.y;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StRun;
            r_x      <= 4'(START_X);
            r_y      <= 4'(START_Y);
            r_dir    <= START_DIR;
            r_hit    <= 1'b0;
            r_escape <= 1'b0;
            r_steps  <= '0;
        end else begin
            case (r_state)
                StRun: begin
                    r_x   <= w_x_d;
                    r_y   <= w_y_d;
                    r_dir <= w_dir_d;
                    r_hit <= w_hit_d;
                    if (w_count && (r_steps != {STEP_W{1'b1}})) begin
                        r_steps <= r_steps + STEP_W'(1);
                    end
                    if (w_x_d == 4'(EXIT_X) && w_y_d == 4'(EXIT_Y)) begin
                        r_escape <= 1'b1;
                        r_state  <= StDone;
                    end
                end
                default: begin
                    r_hit <= 1'b0;
                end
            endcase
        end
    end

    assign pos_x  = r_x;
    assign pos_y  = r_y;
    assign dir    = r_dir;
    assign hit    = r_hit;
    assign escape = r_escape;
    assign steps  = r_steps;

    generate
        if (CHALLENGE) begin : g_ph
            logic [IdxW-1:0] w_addr;
            logic            w_wr_en;
            // Drops land on the pre-move cell, which is the registered position.
            assign w_addr  = IdxW'(int'(r_y) * W + int'(r_x));
            assign w_wr_en = (r_state == StRun) && (ph_drop != '0);
            ant_ph_map #(
                .Depth (W * H),
                .AddrW (IdxW)
            ) u_map (
                .clk     (clk),
                .rst_n   (rst_n),
                .wr_en   (w_wr_en),
                .wr_addr (w_addr),
                .wr_data (ph_drop),
                .rd_addr (w_addr),
                .rd_data (ph_detected)
            );
        end else begin : g_no_ph
            assign ph_detected = '0;
        end
    endgenerate

endmodule

// File: tb/tb_ant_maze_env.sv
// Bench for ant_maze_env: directed scenarios plus randomized walks checked against a
// coordinate-level arena model (open grid A, walled grid B, start-equals-exit grid C).
module tb_ant_maze_env;
    import ant_maze_pkg::*;

    localparam logic [63:0] WALL_B = (64'd1 << 8) | (64'd1 << 10) | (64'd1 << 19) |
                                     (64'd1 << 27) | (64'd1 << 35) | (64'd1 << 36) |
                                     (64'd1 << 44) | (64'd1 << 52) | (64'd1 << 53);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] move_a = HALT, move_b = HALT, move_c = HALT;
    logic [3:0] ph_a = '0, ph_b = '0, ph_c = '0;

    logic a_l, a_r, a_hit, a_esc, b_l, b_r, b_hit, b_esc, c_l, c_r, c_hit, c_esc;
    logic [3:0] a_phd, b_phd, c_phd, a_x, a_y, b_x, b_y, c_x, c_y;
    logic [1:0] a_dir, b_dir, c_dir;
    logic [15:0] a_steps, c_steps;
    logic [3:0] b_steps;

    int checks = 0;
    int errors = 0;

    int m_x[2], m_y[2], m_d[2], m_steps[2];
    bit m_hit[2], m_esc[2];
    int m_ph[2][64];
    int m_cap[2] = '{65535, 15};

    always #(CYC / 2) clk = ~clk;

    ant_maze_env u_a (
        .clk(clk), .rst_n(rst_n), .move(move_a), .ph_drop(ph_a), .ant_l(a_l), .ant_r(a_r),
        .hit(a_hit), .escape(a_esc), .ph_detected(a_phd), .pos_x(a_x), .pos_y(a_y),
        .dir(a_dir), .steps(a_steps)
    );

    ant_maze_env #(.WALL_MAP(WALL_B), .START_DIR(DIR_S), .STEP_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .move(move_b), .ph_drop(ph_b), .ant_l(b_l), .ant_r(b_r),
        .hit(b_hit), .escape(b_esc), .ph_detected(b_phd), .pos_x(b_x), .pos_y(b_y),
        .dir(b_dir), .steps(b_steps)
    );

    ant_maze_env #(.W(4), .H(4), .START_X(2), .START_Y(1), .EXIT_X(2), .EXIT_Y(1)) u_c (
        .clk(clk), .rst_n(rst_n), .move(move_c), .ph_drop(ph_c), .ant_l(c_l), .ant_r(c_r),
        .hit(c_hit), .escape(c_esc), .ph_detected(c_phd), .pos_x(c_x), .pos_y(c_y),
        .dir(c_dir), .steps(c_steps)
    );

    // ---------------- reference model (8x8 arena, exit at (7,7)) ----------------
    function automatic int ddx(input int d);
        return (d == 1) ? 1 : (d == 3) ? -1 : 0;
    endfunction

    function automatic int ddy(input int d);
        return (d == 0) ? -1 : (d == 2) ? 1 : 0;
    endfunction

    function automatic bit cell_blocked(input int id, input int x, input int y);
        logic [63:0] wb;
        wb = WALL_B;
        if (x < 0 || x > 7 || y < 0 || y > 7) return 1'b1;
        if (id == 1) return wb[6'(y * 8 + x)];
        return 1'b0;
    endfunction

    function automatic bit side_blocked(input int id, input int turn);
        int d;
        d = (m_d[id] + turn) % 4;
        return cell_blocked(id, m_x[id] + ddx(d), m_y[id] + ddy(d));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_steps[i] = 0; m_hit[i] = 0; m_esc[i] = 0;
            for (int c = 0; c < 64; c++) m_ph[i][c] = 0;
        end
        m_d[0] = 1;
        m_d[1] = 2;
    endtask

    task automatic model_step(input int id, input logic [1:0] mv, input int drop);
        int nx, ny;
        m_hit[id] = 1'b0;
        if (!m_esc[id]) begin
            if (drop > m_ph[id][m_y[id] * 8 + m_x[id]]) m_ph[id][m_y[id] * 8 + m_x[id]] = drop;
            if (mv != HALT && m_steps[id] < m_cap[id]) m_steps[id]++;
            if (mv == RIGHT) m_d[id] = (m_d[id] + 1) % 4;
            else if (mv == LEFT) m_d[id] = (m_d[id] + 3) % 4;
            else if (mv == FORWARD) begin
                nx = m_x[id] + ddx(m_d[id]);
                ny = m_y[id] + ddy(m_d[id]);
                if (cell_blocked(id, nx, ny)) m_hit[id] = 1'b1;
                else begin
                    m_x[id] = nx;
                    m_y[id] = ny;
                end
            end
            if (m_x[id] == 7 && m_y[id] == 7) m_esc[id] = 1'b1;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(input logic [1:0] ma, input logic [3:0] da,
                        input logic [1:0] mb, input logic [3:0] db);
        move_a = ma; ph_a = da; move_b = mb; ph_b = db;
        @(posedge clk);
        #1;
        model_step(0, ma, int'(da));
        model_step(1, mb, int'(db));
    endtask

    task automatic apply_reset();
        move_a = HALT; move_b = HALT; move_c = HALT;
        ph_a = '0; ph_b = '0;
        rst_n = 1'b0;
        #(CYC * 2);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        checks++;
        if ({a_x, a_y, a_dir, a_hit, a_esc, a_steps} !== {4'd0, 4'd0, 2'd1, 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL reset_a_state got x=%0d y=%0d dir=%0d hit=%0b esc=%0b steps=%0d want 0 0 1 0 0 0",
                     a_x, a_y, a_dir, a_hit, a_esc, a_steps);
        end
        checks++;
        if ({a_l, a_r, a_phd} !== {1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL reset_a_sensors got l=%0b r=%0b ph=%0d want 1 0 0", a_l, a_r, a_phd);
        end
        checks++;
        if ({b_l, b_r, b_dir} !== {1'b0, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL reset_b_sensors got l=%0b r=%0b dir=%0d want 0 1 2", b_l, b_r, b_dir);
        end
        checks++;
        if (c_esc !== 1'b0) begin
            errors++;
            $display("FAIL reset_c_escape got %0b want 0", c_esc);
        end
        tick(HALT, 4'd0, HALT, 4'd0);
        checks++;
        if (c_esc !== 1'b1) begin
            errors++;
            $display("FAIL start_is_exit got escape=%0b want 1", c_esc);
        end
        move_c = FORWARD;
        tick(HALT, 4'd0, HALT, 4'd0);
        move_c = HALT;
        checks++;
        if ({c_x, c_y, c_steps, c_hit} !== {4'd2, 4'd1, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL c_frozen got x=%0d y=%0d steps=%0d hit=%0b want 2 1 0 0",
                     c_x, c_y, c_steps, c_hit);
        end
    endtask

    task automatic test_forward_edge();
        apply_reset();
        for (int i = 0; i < 7; i++) tick(FORWARD, 4'd0, HALT, 4'd0);
        checks++;
        if ({a_x, a_y, a_hit} !== {4'd7, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL fwd7 got x=%0d y=%0d hit=%0b want 7 0 0", a_x, a_y, a_hit);
        end
        tick(FORWARD, 4'd0, HALT, 4'd0);
        checks++;
        if ({a_x, a_y, a_hit, a_steps} !== {4'd7, 4'd0, 1'b1, 16'd8}) begin
            errors++;
            $display("FAIL fwd_edge got x=%0d y=%0d hit=%0b steps=%0d want 7 0 1 8",
                     a_x, a_y, a_hit, a_steps);
        end
    endtask

    task automatic test_turns();
        apply_reset();
        tick(RIGHT, 4'd0, HALT, 4'd0);
        checks++;
        if (a_dir !== 2'd2) begin
            errors++;
            $display("FAIL turn_right got dir=%0d want 2", a_dir);
        end
        tick(LEFT, 4'd0, HALT, 4'd0);
        tick(LEFT, 4'd0, HALT, 4'd0);
        checks++;
        if (a_dir !== 2'd0) begin
            errors++;
            $display("FAIL turn_left2 got dir=%0d want 0", a_dir);
        end
        for (int i = 0; i < 3; i++) tick(HALT, 4'd0, HALT, 4'd0);
        checks++;
        if ({a_dir, a_steps, a_x, a_y} !== {2'd0, 16'd3, 4'd0, 4'd0}) begin
            errors++;
            $display("FAIL halt got dir=%0d steps=%0d x=%0d y=%0d want 0 3 0 0",
                     a_dir, a_steps, a_x, a_y);
        end
    endtask

    task automatic test_wall();
        apply_reset();
        tick(HALT, 4'd0, FORWARD, 4'd0);
        checks++;
        if ({b_hit, b_x, b_y, b_steps} !== {1'b1, 4'd0, 4'd0, 4'd1}) begin
            errors++;
            $display("FAIL wall_hit got hit=%0b x=%0d y=%0d steps=%0d want 1 0 0 1",
                     b_hit, b_x, b_y, b_steps);
        end
        tick(HALT, 4'd0, LEFT, 4'd0);
        checks++;
        if (b_hit !== 1'b0) begin
            errors++;
            $display("FAIL hit_clear got %0b want 0", b_hit);
        end
    endtask

    task automatic test_escape();
        apply_reset();
        for (int i = 0; i < 7; i++) tick(FORWARD, 4'd0, HALT, 4'd0);
        tick(RIGHT, 4'd0, HALT, 4'd0);
        for (int i = 0; i < 6; i++) tick(FORWARD, 4'd0, HALT, 4'd0);
        checks++;
        if (a_esc !== 1'b0) begin
            errors++;
            $display("FAIL early_escape got %0b want 0", a_esc);
        end
        tick(FORWARD, 4'd0, HALT, 4'd0);
        checks++;
        if ({a_esc, a_x, a_y, a_steps} !== {1'b1, 4'd7, 4'd7, 16'd15}) begin
            errors++;
            $display("FAIL escape got esc=%0b x=%0d y=%0d steps=%0d want 1 7 7 15",
                     a_esc, a_x, a_y, a_steps);
        end
        tick(FORWARD, 4'd3, HALT, 4'd0);
        tick(RIGHT, 4'd0, HALT, 4'd0);
        checks++;
        if ({a_esc, a_x, a_y, a_dir, a_steps, a_hit, a_phd} !==
            {1'b1, 4'd7, 4'd7, 2'd2, 16'd15, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL done_frozen got esc=%0b x=%0d y=%0d dir=%0d steps=%0d hit=%0b ph=%0d",
                     a_esc, a_x, a_y, a_dir, a_steps, a_hit, a_phd);
        end
    endtask

    task automatic test_pheromone();
        apply_reset();
        tick(HALT, 4'd1, HALT, 4'd0);
        checks++;
        if (a_phd !== 4'd1) begin
            errors++;
            $display("FAIL ph_drop1 got %0d want 1", a_phd);
        end
        tick(HALT, 4'd0, HALT, 4'd0);
        tick(HALT, 4'd5, HALT, 4'd0);
        tick(HALT, 4'd3, HALT, 4'd0);
        checks++;
        if (a_phd !== 4'd5) begin
            errors++;
            $display("FAIL ph_max got %0d want 5", a_phd);
        end
        tick(FORWARD, 4'd0, HALT, 4'd0);
        checks++;
        if ({a_x, a_phd} !== {4'd1, 4'd0}) begin
            errors++;
            $display("FAIL ph_new_cell got x=%0d ph=%0d want 1 0", a_x, a_phd);
        end
        tick(FORWARD, 4'd9, HALT, 4'd0);
        tick(LEFT, 4'd0, HALT, 4'd0);
        tick(LEFT, 4'd0, HALT, 4'd0);
        checks++;
        if ({a_x, a_phd} !== {4'd2, 4'd0}) begin
            errors++;
            $display("FAIL ph_premove_dest got x=%0d ph=%0d want 2 0", a_x, a_phd);
        end
        tick(FORWARD, 4'd0, HALT, 4'd0);
        checks++;
        if ({a_x, a_phd} !== {4'd1, 4'd9}) begin
            errors++;
            $display("FAIL ph_premove_src got x=%0d ph=%0d want 1 9", a_x, a_phd);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        tick(FORWARD, 4'd7, HALT, 4'd0);
        for (int i = 0; i < 3; i++) tick(FORWARD, 4'd0, HALT, 4'd0);
        checks++;
        if ({a_x, a_steps} !== {4'd4, 16'd4}) begin
            errors++;
            $display("FAIL pre_reset got x=%0d steps=%0d want 4 4", a_x, a_steps);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_x, a_y, a_dir, a_steps, a_hit, c_esc} !==
            {4'd0, 4'd0, 2'd1, 16'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got x=%0d y=%0d dir=%0d steps=%0d hit=%0b c_esc=%0b",
                     a_x, a_y, a_dir, a_steps, a_hit, c_esc);
        end
        checks++;
        if (a_phd !== 4'd0) begin
            errors++;
            $display("FAIL map_cleared got %0d want 0", a_phd);
        end
        apply_reset();
    endtask

    task automatic test_random();
        logic [1:0]  ma, mb;
        logic [3:0]  da, db;
        logic [27:0] got_a, exp_a;
        logic [15:0] got_b, exp_b;
        logic [5:0]  sg_a, se_a, sg_b, se_b;
        int r;
        for (int round = 0; round < 4; round++) begin
            apply_reset();
            for (int c = 0; c < 150; c++) begin
                r  = $urandom_range(0, 9);
                mb = (r < 5) ? FORWARD : (r < 7) ? RIGHT : (r < 9) ? LEFT : HALT;
                ma = 2'($urandom_range(0, 3));
                da = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                db = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                tick(ma, da, mb, db);
                got_a = {a_x, a_y, a_dir, a_hit, a_esc, a_steps};
                exp_a = {4'(m_x[0]), 4'(m_y[0]), 2'(m_d[0]), m_hit[0], m_esc[0], 16'(m_steps[0])};
                got_b = {b_x, b_y, b_dir, b_hit, b_esc, b_steps};
                exp_b = {4'(m_x[1]), 4'(m_y[1]), 2'(m_d[1]), m_hit[1], m_esc[1], 4'(m_steps[1])};
                sg_a = {a_l, a_r, a_phd};
                se_a = {side_blocked(0, 3), side_blocked(0, 1), 4'(m_ph[0][m_y[0] * 8 + m_x[0]])};
                sg_b = {b_l, b_r, b_phd};
                se_b = {side_blocked(1, 3), side_blocked(1, 1), 4'(m_ph[1][m_y[1] * 8 + m_x[1]])};
                checks++;
                if (got_a !== exp_a) begin
                    errors++;
                    $display("FAIL rand_a_state cyc=%0d got %h want %h", c, got_a, exp_a);
                end
                checks++;
                if (got_b !== exp_b) begin
                    errors++;
                    $display("FAIL rand_b_state cyc=%0d got %h want %h", c, got_b, exp_b);
                end
                checks++;
                if (sg_a !== se_a) begin
                    errors++;
                    $display("FAIL rand_a_sense cyc=%0d got %h want %h", c, sg_a, se_a);
                end
                checks++;
                if (sg_b !== se_b) begin
                    errors++;
                    $display("FAIL rand_b_sense cyc=%0d got %h want %h", c, sg_b, se_b);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_forward_edge();
        test_turns();
        test_wall();
        test_escape();
        test_pheromone();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
